// File: rtl/serv_bus_pkg.sv
// ----------------------------------------------------------------------------
// serv_bus_pkg
// Shared types and constants for the SERV ibus/dbus to Wishbone arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : which master owns the slave bus
//   SEL_ALL     : byte-enable pattern used for instruction fetches
// ----------------------------------------------------------------------------
package serv_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        GNT_IBUS,
        GNT_DBUS
    } arb_grant_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/bus_timeout_timer.sv
// ----------------------------------------------------------------------------
// bus_timeout_timer
// Saturating up-counter that flags a hung slave transaction.
//   clk       in  core clock
//   rst       in  asynchronous, active-high reset
//   clear_i   in  synchronous clear to zero (has priority over enable_i)
//   enable_i  in  count one per cycle while high
//   expired_o out high while enabled and the count has reached TIMEOUT-1
// TIMEOUT = 0 disables the timer: expired_o is then constantly low.
// ----------------------------------------------------------------------------
module bus_timeout_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturate rather than wrap so a stuck enable can never re-arm a
    // count that has already passed the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign expired_o = enable_i && (count_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serv_bus_arbiter.sv
// ----------------------------------------------------------------------------
// serv_bus_arbiter
// 2:1 round-robin arbiter merging the SERV instruction bus (read-only) and
// data bus onto one Wishbone slave bus. One outstanding transaction,
// registered request/response paths, bus-hang timeout.
//
// Ports
//   clk, rst                          core clock, async active-high reset
//   i_ibus_adr/cyc, o_ibus_rdt/ack    instruction fetch master
//   i_dbus_adr/dat/sel/we/cyc,
//   o_dbus_rdt/ack                    load/store master
//   o_cyc/stb/we/adr/dat/sel          slave request (cyc and stb identical)
//   i_dat, i_ack                      slave response
//   o_err                             pulses with the master ack of a
//                                     timed-out transaction
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARB_IDLE | no transaction; arbitrate the masters' cyc lines
// ARB_BUSY | slave cycle open, waiting for i_ack, timeout or master abort
// ARB_DONE | granted master's ack high for this one cycle; bus turnaround
// ----------------------------------------------------------------------------
module serv_bus_arbiter
    import serv_bus_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_ibus_adr,
    input  logic              i_ibus_cyc,
    output logic [DATA_W-1:0] o_ibus_rdt,
    output logic              o_ibus_ack,

    input  logic [ADDR_W-1:0] i_dbus_adr,
    input  logic [DATA_W-1:0] i_dbus_dat,
    input  logic [3:0]        i_dbus_sel,
    input  logic              i_dbus_we,
    input  logic              i_dbus_cyc,
    output logic [DATA_W-1:0] o_dbus_rdt,
    output logic              o_dbus_ack,

    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_adr,
    output logic [DATA_W-1:0] o_dat,
    output logic [3:0]        o_sel,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_ack,
    output logic              o_err
);

    arb_state_t        state_q;
    arb_grant_t        grant_q;
    arb_grant_t        last_grant_q;
    arb_grant_t        grant_d;

    logic              cyc_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] ibus_rdt_q;
    logic [DATA_W-1:0] dbus_rdt_q;
    logic              ibus_ack_q;
    logic              dbus_ack_q;
    logic              err_q;

    logic              granted_cyc;
    logic              timer_expired;

    // Round robin only matters on a tie; otherwise the lone requester wins.
    always_comb begin
        grant_d = GNT_DBUS;
        if (i_ibus_cyc && i_dbus_cyc) begin
            grant_d = (last_grant_q == GNT_DBUS) ? GNT_IBUS : GNT_DBUS;
        end else if (i_ibus_cyc) begin
            grant_d = GNT_IBUS;
        end
    end

    assign granted_cyc = (grant_q == GNT_IBUS) ? i_ibus_cyc : i_dbus_cyc;

    bus_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == ARB_IDLE),
        .enable_i  (state_q == ARB_BUSY),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GNT_IBUS;
            last_grant_q <= GNT_DBUS;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            ibus_rdt_q   <= '0;
            dbus_rdt_q   <= '0;
            ibus_ack_q   <= 1'b0;
            dbus_ack_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                ARB_IDLE: begin
                    if (i_ibus_cyc || i_dbus_cyc) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        cyc_q        <= 1'b1;
                        state_q      <= ARB_BUSY;
                        if (grant_d == GNT_IBUS) begin
                            adr_q <= i_ibus_adr;
                            dat_q <= '0;
                            sel_q <= SEL_ALL;
                            we_q  <= 1'b0;
                        end else begin
                            adr_q <= i_dbus_adr;
                            dat_q <= i_dbus_dat;
                            sel_q <= i_dbus_sel;
                            we_q  <= i_dbus_we;
                        end
                    end
                end

                ARB_BUSY: begin
                    // An abandoning master gets no ack even if the slave
                    // answers in the same cycle: it is no longer listening.
                    if (!granted_cyc) begin
                        cyc_q   <= 1'b0;
                        state_q <= ARB_IDLE;
                    end else if (i_ack || timer_expired) begin
                        cyc_q   <= 1'b0;
                        err_q   <= !i_ack;
                        state_q <= ARB_DONE;
                        if (grant_q == GNT_IBUS) begin
                            ibus_rdt_q <= i_ack ? i_dat : ERR_DATA;
                            ibus_ack_q <= 1'b1;
                        end else begin
                            dbus_rdt_q <= i_ack ? i_dat : ERR_DATA;
                            dbus_ack_q <= 1'b1;
                        end
                    end
                end

                ARB_DONE: begin
                    state_q <= ARB_IDLE;
                end

                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_cyc      = cyc_q;
    assign o_stb      = cyc_q;
    assign o_we       = we_q;
    assign o_adr      = adr_q;
    assign o_dat      = dat_q;
    assign o_sel      = sel_q;
    assign o_ibus_rdt = ibus_rdt_q;
    assign o_ibus_ack = ibus_ack_q;
    assign o_dbus_rdt = dbus_rdt_q;
    assign o_dbus_ack = dbus_ack_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
module tb_serv_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we  = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic        o_cyc, o_stb, o_we, o_err;
    logic [31:0] o_adr, o_dat;
    logic [3:0]  o_sel;
    logic [31:0] i_dat = '0;
    logic        i_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serv_bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_cyc      (o_cyc),
        .o_stb      (o_stb),
        .o_we       (o_we),
        .o_adr      (o_adr),
        .o_dat      (o_dat),
        .o_sel      (o_sel),
        .i_dat      (i_dat),
        .i_ack      (i_ack),
        .o_err      (o_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        #12;
        chk("rst_cyc", {31'd0, o_cyc}, 32'd0);
        chk("rst_ibus_ack", {31'd0, o_ibus_ack}, 32'd0);
        chk("rst_adr", o_adr, 32'd0);
        chk("rst_sel", {28'd0, o_sel}, 32'd0);
        rst = 1'b0;
        step();

        // ---------------- 1: ibus read 0x100, ack 2 cycles after o_cyc ----------------
        i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
        step();
        chk("t1_cyc", {31'd0, o_cyc}, 32'd1);
        chk("t1_stb", {31'd0, o_stb}, 32'd1);
        chk("t1_adr", o_adr, 32'h100);
        chk("t1_we", {31'd0, o_we}, 32'd0);
        chk("t1_sel", {28'd0, o_sel}, 32'hF);
        step();
        chk("t1_wait_cyc", {31'd0, o_cyc}, 32'd1);
        chk("t1_wait_ack", {31'd0, o_ibus_ack}, 32'd0);
        step();
        i_ack = 1'b1; i_dat = 32'h13;
        step();
        i_ack = 1'b0; i_dat = 32'h0;
        chk("t1_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
        chk("t1_ibus_rdt", o_ibus_rdt, 32'h13);
        chk("t1_dbus_ack", {31'd0, o_dbus_ack}, 32'd0);
        chk("t1_cyc_drop", {31'd0, o_cyc}, 32'd0);
        i_ibus_cyc = 1'b0;
        step();
        chk("t1_ack_pulse", {31'd0, o_ibus_ack}, 32'd0);
        chk("t1_rdt_hold", o_ibus_rdt, 32'h13);

        // ---------------- 2: dbus store, immediate slave ack ----------------
        i_dbus_adr = 32'h2000; i_dbus_dat = 32'hA5A5_0001; i_dbus_sel = 4'h3;
        i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;     // request cycle 0
        step();                                   // cycle 1
        chk("t2_cyc", {31'd0, o_cyc}, 32'd1);
        chk("t2_we", {31'd0, o_we}, 32'd1);
        chk("t2_sel", {28'd0, o_sel}, 32'h3);
        chk("t2_dat", o_dat, 32'hA5A5_0001);
        chk("t2_adr", o_adr, 32'h2000);
        i_ack = 1'b1;
        step();                                   // cycle 2: master ack
        i_ack = 1'b0;
        chk("t2_dbus_ack", {31'd0, o_dbus_ack}, 32'd1);
        chk("t2_ibus_ack", {31'd0, o_ibus_ack}, 32'd0);
        chk("t2_err", {31'd0, o_err}, 32'd0);
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        step();
        chk("t2_ack_pulse", {31'd0, o_dbus_ack}, 32'd0);

        // ---------------- 3: simultaneous requests, round robin ----------------
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        i_ibus_adr = 32'h300; i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h400; i_dbus_sel = 4'hC; i_dbus_cyc = 1'b1;
        step();
        chk("t3a_first_adr", o_adr, 32'h300);
        chk("t3a_first_sel", {28'd0, o_sel}, 32'hF);
        i_ack = 1'b1; i_dat = 32'h11;
        step();
        i_ack = 1'b0;
        chk("t3a_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
        chk("t3a_dbus_noack", {31'd0, o_dbus_ack}, 32'd0);
        i_ibus_cyc = 1'b0;
        step();                                   // mandatory idle cycle
        chk("t3a_idle_cyc", {31'd0, o_cyc}, 32'd0);
        step();
        chk("t3a_second_adr", o_adr, 32'h400);
        chk("t3a_second_cyc", {31'd0, o_cyc}, 32'd1);
        i_ack = 1'b1; i_dat = 32'h22;
        step();
        i_ack = 1'b0;
        chk("t3a_dbus_ack", {31'd0, o_dbus_ack}, 32'd1);
        chk("t3a_dbus_rdt", o_dbus_rdt, 32'h22);
        i_dbus_cyc = 1'b0;
        step();
        // a lone fetch makes ibus the last grant, so the next tie goes to dbus
        i_ibus_adr = 32'h500; i_ibus_cyc = 1'b1;
        step();
        i_ack = 1'b1; i_dat = 32'h55;
        step();
        i_ack = 1'b0;
        chk("t3b_lone_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
        i_ibus_cyc = 1'b0;
        step();
        i_ibus_adr = 32'h600; i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h700; i_dbus_cyc = 1'b1;
        step();
        chk("t3b_first_adr", o_adr, 32'h700);
        i_ack = 1'b1; i_dat = 32'h66;
        step();
        i_ack = 1'b0;
        chk("t3b_dbus_ack", {31'd0, o_dbus_ack}, 32'd1);
        chk("t3b_ibus_noack", {31'd0, o_ibus_ack}, 32'd0);
        i_dbus_cyc = 1'b0;
        step();
        step();
        chk("t3b_second_adr", o_adr, 32'h600);
        i_ack = 1'b1; i_dat = 32'h77;
        step();
        i_ack = 1'b0;
        chk("t3b_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
        chk("t3b_ibus_rdt", o_ibus_rdt, 32'h77);
        i_ibus_cyc = 1'b0;
        step();

        // ---------------- 4: timeout (TIMEOUT=8) ----------------
        i_ibus_adr = 32'h800; i_ibus_cyc = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_busy_cyc%0d", i), {31'd0, o_cyc}, 32'd1);
            chk($sformatf("t4_busy_noack%0d", i), {31'd0, o_ibus_ack}, 32'd0);
            step();
        end
        chk("t4_cyc_drop", {31'd0, o_cyc}, 32'd0);
        chk("t4_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
        chk("t4_rdt", o_ibus_rdt, 32'hDEADBEEF);
        chk("t4_err", {31'd0, o_err}, 32'd1);
        i_ibus_cyc = 1'b0;
        step();
        chk("t4_err_pulse", {31'd0, o_err}, 32'd0);
        chk("t4_ack_pulse", {31'd0, o_ibus_ack}, 32'd0);

        // ---------------- 5: dbus abort ----------------
        i_dbus_adr = 32'h900; i_dbus_we = 1'b1; i_dbus_sel = 4'hF;
        i_dbus_dat = 32'h1234_5678; i_dbus_cyc = 1'b1;
        step();
        chk("t5_cyc", {31'd0, o_cyc}, 32'd1);
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        step();
        chk("t5_abort_cyc", {31'd0, o_cyc}, 32'd0);
        chk("t5_abort_noack", {31'd0, o_dbus_ack}, 32'd0);
        step();
        chk("t5_abort_noack2", {31'd0, o_dbus_ack}, 32'd0);
        chk("t5_rdt_unchanged", o_dbus_rdt, 32'h66);
        i_ibus_adr = 32'hA00; i_ibus_cyc = 1'b1;
        step();
        chk("t5_next_adr", o_adr, 32'hA00);
        chk("t5_next_we", {31'd0, o_we}, 32'd0);
        i_ack = 1'b1; i_dat = 32'h33;
        step();
        i_ack = 1'b0;
        chk("t5_next_ack", {31'd0, o_ibus_ack}, 32'd1);
        chk("t5_next_rdt", o_ibus_rdt, 32'h33);
        i_ibus_cyc = 1'b0;
        step();

        // ---------------- 6: async reset mid-BUSY, spurious ack ----------------
        i_ibus_adr = 32'hB00; i_ibus_cyc = 1'b1;
        step();
        chk("t6_busy_cyc", {31'd0, o_cyc}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cyc", {31'd0, o_cyc}, 32'd0);
        chk("t6_rst_stb", {31'd0, o_stb}, 32'd0);
        chk("t6_rst_adr", o_adr, 32'd0);
        chk("t6_rst_sel", {28'd0, o_sel}, 32'd0);
        chk("t6_rst_ibus_rdt", o_ibus_rdt, 32'd0);
        rst = 1'b0;
        i_ibus_cyc = 1'b0;
        step();
        i_ack = 1'b1; i_dat = 32'hFFFF_0000;
        step();
        chk("t6_spur_cyc", {31'd0, o_cyc}, 32'd0);
        step();
        i_ack = 1'b0;
        chk("t6_spur_ibus_ack", {31'd0, o_ibus_ack}, 32'd0);
        chk("t6_spur_dbus_ack", {31'd0, o_dbus_ack}, 32'd0);
        chk("t6_spur_rdt", o_ibus_rdt, 32'd0);
        step();
        chk("t6_after_cyc", {31'd0, o_cyc}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
